// File: rtl/ram512x32_rr_arbiter.sv
// Round-robin arbiter and sequencer for one 512x32 dual-port RAM.
// The write port and the read port are arbitrated independently. All RAM pins are
// driven from registers. Reads return tagged to the requester that issued them.
// A read is held back while a write to the same address is still on its way in.
module ram512x32_rr_arbiter #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32,
   parameter int BE_W   = 4,
   // Only 1 (unregistered RAM output) or 2 (registered RAM output) are meaningful
   parameter int RD_LAT = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [1:0]          req_i,
   input  logic [1:0]          wr_i,
   input  logic [2*ADDR_W-1:0] addr_i,
   input  logic [2*DATA_W-1:0] wdata_i,
   input  logic [2*BE_W-1:0]   ben_i,
   output logic [1:0]          gnt_o,
   output logic [1:0]          rvalid_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic [ADDR_W-1:0]   ram_wa_o,
   output logic [DATA_W-1:0]   ram_wd_o,
   output logic [BE_W-1:0]     ram_wen_o,
   output logic                ram_wclk_en_o,
   output logic [ADDR_W-1:0]   ram_ra_o,
   output logic                ram_rclk_en_o,
   input  logic [DATA_W-1:0]   ram_rd_i
);

   logic [ADDR_W-1:0] addr0, addr1;
   logic [1:0]        wrCand, rdCand, hazard;
   logic [1:0]        wrGnt, rdGnt;
   logic              wrSel, rdSel;
   logic [ADDR_W-1:0] wrAddr;
   logic              wrPtr_q, wrPtr_d;
   logic              rdPtr_q, rdPtr_d;

   logic [ADDR_W-1:0] ramWa_q, ramRa_q;
   logic [DATA_W-1:0] ramWd_q, rdata_q;
   logic [BE_W-1:0]   ramWen_q;
   logic              ramWclkEn_q, ramRclkEn_q;
   logic [1:0]        rvalid_q;
   logic [RD_LAT:0]   tagValid_q, tagId_q;

   assign addr0 = addr_i[ADDR_W-1:0];
   assign addr1 = addr_i[2*ADDR_W-1:ADDR_W];

   // Pick the write winner first, then mask reads that would overtake a pending write
   // to the same address, then pick the read winner from what is left.
   always_comb begin
      wrCand  = req_i & wr_i;
      wrGnt   = 2'b00;
      rdGnt   = 2'b00;
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      if (!rst_i) begin
         if (wrCand == 2'b11) wrGnt = wrPtr_q ? 2'b10 : 2'b01;
         else                 wrGnt = wrCand;
      end
      wrSel  = wrGnt[1];
      wrAddr = wrSel ? addr1 : addr0;
      hazard[0] = ((|wrGnt) && (addr0 == wrAddr)) || (ramWclkEn_q && (addr0 == ramWa_q));
      hazard[1] = ((|wrGnt) && (addr1 == wrAddr)) || (ramWclkEn_q && (addr1 == ramWa_q));
      rdCand = req_i & ~wr_i & ~hazard;
      if (!rst_i) begin
         if (rdCand == 2'b11) rdGnt = rdPtr_q ? 2'b10 : 2'b01;
         else                 rdGnt = rdCand;
      end
      rdSel = rdGnt[1];
      if (|wrGnt) wrPtr_d = ~wrSel;
      if (|rdGnt) rdPtr_d = ~rdSel;
   end

   assign gnt_o = wrGnt | rdGnt;

   // Register the granted operations onto the RAM pins and walk read tags down the
   // latency pipe so the returning data lands with the right requester.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wrPtr_q     <= 1'b0;
         rdPtr_q     <= 1'b0;
         ramWa_q     <= '0;
         ramWd_q     <= '0;
         ramWen_q    <= '0;
         ramWclkEn_q <= 1'b0;
         ramRa_q     <= '0;
         ramRclkEn_q <= 1'b0;
         tagValid_q  <= '0;
         tagId_q     <= '0;
         rvalid_q    <= 2'b00;
         rdata_q     <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         if (|wrGnt) begin
            ramWa_q     <= wrAddr;
            ramWd_q     <= wrSel ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];
            ramWen_q    <= wrSel ? ben_i[2*BE_W-1:BE_W] : ben_i[BE_W-1:0];
            ramWclkEn_q <= 1'b1;
         end else begin
            ramWen_q    <= '0;
            ramWclkEn_q <= 1'b0;
         end
         if (|rdGnt) begin
            ramRa_q     <= rdSel ? addr1 : addr0;
            ramRclkEn_q <= 1'b1;
         end else begin
            ramRclkEn_q <= 1'b0;
         end
         tagValid_q <= {tagValid_q[RD_LAT-1:0], |rdGnt};
         tagId_q    <= {tagId_q[RD_LAT-1:0], rdSel};
         rvalid_q   <= 2'b00;
         if (tagValid_q[RD_LAT]) begin
            rvalid_q[tagId_q[RD_LAT]] <= 1'b1;
            rdata_q                   <= ram_rd_i;
         end
      end
   end

   assign rvalid_o      = rvalid_q;
   assign rdata_o       = rdata_q;
   assign ram_wa_o      = ramWa_q;
   assign ram_wd_o      = ramWd_q;
   assign ram_wen_o     = ramWen_q;
   assign ram_wclk_en_o = ramWclkEn_q;
   assign ram_ra_o      = ramRa_q;
   assign ram_rclk_en_o = ramRclkEn_q;

endmodule

// File: tb/tb_ram512x32_rr_arbiter.sv
// Directed bench for ram512x32_rr_arbiter with a behavioural 512x32 RAM attached
// (unregistered read output, byte-enabled writes).
module tb_ram512x32_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req, wr;
   logic [8:0]  a0, a1;
   logic [31:0] d0, d1;
   logic [3:0]  b0, b1;
   logic [1:0]  gnt, rvalid;
   logic [31:0] rdata;
   logic [8:0]  ramWa, ramRa;
   logic [31:0] ramWd, ramRd;
   logic [3:0]  ramWen;
   logic        ramWclkEn, ramRclkEn;
   logic [31:0] mem [512];
   logic [31:0] ramWord;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   ram512x32_rr_arbiter #(.ADDR_W(9), .DATA_W(32), .BE_W(4), .RD_LAT(1)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .wr_i(wr),
      .addr_i({a1, a0}), .wdata_i({d1, d0}), .ben_i({b1, b0}),
      .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
      .ram_wa_o(ramWa), .ram_wd_o(ramWd), .ram_wen_o(ramWen), .ram_wclk_en_o(ramWclkEn),
      .ram_ra_o(ramRa), .ram_rclk_en_o(ramRclkEn), .ram_rd_i(ramRd)
   );

   // Behavioural RAM: byte-masked write and read-address sampling on the shared clock
   always @(posedge clk) begin
      if (ramWclkEn) begin
         ramWord = mem[ramWa];
         for (int b = 0; b < 4; b++)
            if (ramWen[b]) ramWord[8*b +: 8] = ramWd[8*b +: 8];
         mem[ramWa] <= ramWord;
      end
      if (ramRclkEn) ramRd <= mem[ramRa];
   end

   // Drive one cycle of inputs just after the falling edge, then let them settle
   task automatic applyStimulus(input logic r, input logic [1:0] rq, input logic [1:0] w,
                                input logic [8:0] x0, input logic [8:0] x1,
                                input logic [31:0] y0, input logic [31:0] y1,
                                input logic [3:0] z0, input logic [3:0] z1);
      @(negedge clk);
      rst = r; req = rq; wr = w; a0 = x0; a1 = x1; d0 = y0; d1 = y1; b0 = z0; b1 = z1;
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 2'b00, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0, 4'h0, 4'h0);
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst = 1'b1; req = 2'b11; wr = 2'b01;
      a0 = 9'h005; a1 = 9'h005; d0 = '0; d1 = '0; b0 = 4'hF; b1 = 4'hF;

      // Reset held three cycles with both requesting
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 2'b11, 2'b01, 9'h005, 9'h005, 32'h0, 32'h0, 4'hF, 4'hF);
         checkOutput("rst gnt", gnt, 2'b00);
         checkOutput("rst rvalid", rvalid, 2'b00);
         checkOutput("rst wclk_en", ramWclkEn, 1'b0);
         checkOutput("rst rclk_en", ramRclkEn, 1'b0);
      end

      // Both write every cycle: grants alternate starting with req0
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b0, 2'b11, 2'b11, 9'h020, 9'h021, 32'h11111111, 32'h22222222, 4'hF, 4'hF);
         checkOutput("rr wr gnt", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
         if (k > 0) begin
            checkOutput("rr wclk_en", ramWclkEn, 1'b1);
            checkOutput("rr ram_wa", ramWa, ((k - 1) % 2 == 0) ? 9'h020 : 9'h021);
         end
      end
      idle();
      checkOutput("rr last wclk_en", ramWclkEn, 1'b1);
      checkOutput("rr last ram_wa", ramWa, 9'h021);
      checkOutput("rr last ram_wd", ramWd, 32'h22222222);
      idle();
      checkOutput("rr wclk_en off", ramWclkEn, 1'b0);
      checkOutput("rr wen off", ramWen, 4'h0);

      // Write then read the same address from req0
      applyStimulus(1'b0, 2'b01, 2'b01, 9'h005, 9'h0, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0);
      checkOutput("raw wr gnt", gnt, 2'b01);
      applyStimulus(1'b0, 2'b01, 2'b00, 9'h005, 9'h0, 32'h0, 32'h0, 4'h0, 4'h0);
      checkOutput("raw rd masked", gnt, 2'b00);
      checkOutput("raw wclk_en", ramWclkEn, 1'b1);
      checkOutput("raw ram_wa", ramWa, 9'h005);
      checkOutput("raw ram_wd", ramWd, 32'hDEADBEEF);
      checkOutput("raw ram_wen", ramWen, 4'hF);
      applyStimulus(1'b0, 2'b01, 2'b00, 9'h005, 9'h0, 32'h0, 32'h0, 4'h0, 4'h0);
      checkOutput("raw rd gnt", gnt, 2'b01);
      idle();
      checkOutput("raw rclk_en", ramRclkEn, 1'b1);
      checkOutput("raw ram_ra", ramRa, 9'h005);
      idle();
      checkOutput("raw rvalid early", rvalid, 2'b00);
      idle();
      checkOutput("raw rvalid", rvalid, 2'b01);
      checkOutput("raw rdata", rdata, 32'hDEADBEEF);
      idle();
      checkOutput("raw rvalid pulse", rvalid, 2'b00);

      // Partial byte write over a full word, then read back the merge
      applyStimulus(1'b0, 2'b10, 2'b10, 9'h0, 9'h010, 32'h0, 32'hFFFFFFFF, 4'h0, 4'hF);
      checkOutput("be init gnt", gnt, 2'b10);
      applyStimulus(1'b0, 2'b01, 2'b01, 9'h010, 9'h0, 32'h12345678, 32'h0, 4'b0011, 4'h0);
      checkOutput("be wr gnt", gnt, 2'b01);
      applyStimulus(1'b0, 2'b01, 2'b00, 9'h010, 9'h0, 32'h0, 32'h0, 4'h0, 4'h0);
      checkOutput("be rd masked", gnt, 2'b00);
      checkOutput("be ram_wen", ramWen, 4'b0011);
      applyStimulus(1'b0, 2'b01, 2'b00, 9'h010, 9'h0, 32'h0, 32'h0, 4'h0, 4'h0);
      checkOutput("be rd gnt", gnt, 2'b01);
      idle();
      idle();
      checkOutput("be rvalid early", rvalid, 2'b00);
      idle();
      checkOutput("be rvalid", rvalid, 2'b01);
      checkOutput("be rdata", rdata, 32'hFFFF5678);

      // Same-cycle write and read of 0x1FF from different requesters
      applyStimulus(1'b0, 2'b11, 2'b01, 9'h1FF, 9'h1FF, 32'hCAFEF00D, 32'h0, 4'hF, 4'h0);
      checkOutput("same wr gnt", gnt, 2'b01);
      applyStimulus(1'b0, 2'b10, 2'b00, 9'h0, 9'h1FF, 32'h0, 32'h0, 4'h0, 4'h0);
      checkOutput("same rd masked", gnt, 2'b00);
      applyStimulus(1'b0, 2'b10, 2'b00, 9'h0, 9'h1FF, 32'h0, 32'h0, 4'h0, 4'h0);
      checkOutput("same rd gnt", gnt, 2'b10);
      idle();
      checkOutput("same ram_ra", ramRa, 9'h1FF);
      idle();
      checkOutput("same rvalid early", rvalid, 2'b00);
      idle();
      checkOutput("same rvalid", rvalid, 2'b10);
      checkOutput("same rdata", rdata, 32'hCAFEF00D);

      // Back-to-back reads, then reset one cycle after the last grant
      applyStimulus(1'b0, 2'b10, 2'b00, 9'h0, 9'h000, 32'h0, 32'h0, 4'h0, 4'h0);
      checkOutput("b2b gnt0", gnt, 2'b10);
      applyStimulus(1'b0, 2'b11, 2'b00, 9'h001, 9'h002, 32'h0, 32'h0, 4'h0, 4'h0);
      checkOutput("b2b gnt1", gnt, 2'b01);
      applyStimulus(1'b0, 2'b11, 2'b00, 9'h003, 9'h002, 32'h0, 32'h0, 4'h0, 4'h0);
      checkOutput("b2b gnt2", gnt, 2'b10);
      applyStimulus(1'b0, 2'b01, 2'b00, 9'h003, 9'h0, 32'h0, 32'h0, 4'h0, 4'h0);
      checkOutput("b2b gnt3", gnt, 2'b01);
      checkOutput("b2b rvalid0", rvalid, 2'b10);
      applyStimulus(1'b1, 2'b00, 2'b00, 9'h0, 9'h0, 32'h0, 32'h0, 4'h0, 4'h0);
      checkOutput("b2b rst gnt", gnt, 2'b00);
      checkOutput("b2b rvalid1", rvalid, 2'b01);
      idle();
      checkOutput("b2b dropped a", rvalid, 2'b00);
      applyStimulus(1'b0, 2'b11, 2'b11, 9'h040, 9'h041, 32'h1, 32'h2, 4'hF, 4'hF);
      checkOutput("b2b dropped b", rvalid, 2'b00);
      checkOutput("ptr wr after rst", gnt, 2'b01);
      applyStimulus(1'b0, 2'b11, 2'b00, 9'h050, 9'h051, 32'h0, 32'h0, 4'h0, 4'h0);
      checkOutput("ptr rd after rst", gnt, 2'b01);
      checkOutput("b2b dropped c", rvalid, 2'b00);
      idle();
      checkOutput("b2b dropped d", rvalid, 2'b00);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
